// File: rtl/vred_seq_ctrl.sv
// Sequencer for the vector reduction sum/min/max block: folds source beats into a
// lane-wise accumulator, folds it horizontally to one element, returns the scalar.
module vred_seq_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int OPSEL_WIDTH = 9,
    parameter int SEW_WIDTH   = 2,
    parameter int MAX_BEATS   = 16,
    parameter int CNT_W       = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    input  logic [SEW_WIDTH-1:0]    sew,
    input  logic [OPSEL_WIDTH-1:0]  opSel,
    output logic                    red_en,
    output logic [SEW_WIDTH-1:0]    red_sew,
    output logic [OPSEL_WIDTH-1:0]  red_opSel,
    output logic [2*DATA_WIDTH-1:0] red_vec0,
    input  logic [DATA_WIDTH-1:0]   red_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_err,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC_WAIT,
        S_ACC_ISSUE,
        S_FOLD_ISSUE,
        S_FOLD_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [CNT_W-1:0]       cnt;
    logic [SEW_WIDTH-1:0]   fidx;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [OPSEL_WIDTH-1:0] opsel_q;
    logic                   last_q;
    logic                   err_q;

    logic                   accept;
    logic [SEW_WIDTH-1:0]   fold_cnt;
    int                     fold_shift;
    logic                   limit_hit;

    function automatic logic [DATA_WIDTH-1:0] sew_mask(input logic [SEW_WIDTH-1:0] s);
        int bits;
        bits = 8 << s;
        if (bits >= DATA_WIDTH) return '1;
        return {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - bits);
    endfunction

    // Only IDLE and ACC_ISSUE ever raise in_ready, so this is the beat handshake.
    assign accept     = in_valid && in_ready;
    assign fold_cnt   = SEW_WIDTH'(3) - sew_q;
    assign fold_shift = (DATA_WIDTH / 2) >> fidx;
    assign limit_hit  = (cnt == CNT_W'(MAX_BEATS));
    assign busy       = (state != S_IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        red_en    = 1'b0;
        red_sew   = '0;
        red_opSel = '0;
        red_vec0  = '0;
        case (state)
            S_IDLE: if (accept) begin
                red_sew   = sew;
                red_opSel = opSel;
                red_vec0  = {{DATA_WIDTH{1'b0}}, in_data};
            end
            S_ACC_ISSUE: if (accept) begin
                red_en    = 1'b1;
                red_sew   = sew_q;
                red_opSel = opsel_q;
                red_vec0  = {in_data, acc};
            end
            S_FOLD_ISSUE: begin
                red_en    = 1'b1;
                red_sew   = sew_q;
                red_opSel = opsel_q;
                red_vec0  = {acc >> fold_shift, acc};
            end
            default: ;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch reads the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            fidx      <= '0;
            sew_q     <= '0;
            opsel_q   <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sew_q    <= sew;
                        opsel_q  <= opSel;
                        cnt      <= CNT_W'(1);
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        state    <= S_ACC_WAIT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_ACC_ISSUE: begin
                    if (accept) begin
                        cnt      <= cnt + CNT_W'(1);
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        state    <= S_ACC_WAIT;
                    end
                end
                S_ACC_WAIT: begin
                    acc <= red_result;
                    if (last_q || limit_hit) begin
                        // A last beat landing exactly on the limit is a clean finish.
                        err_q <= !last_q;
                        fidx  <= '0;
                        if (fold_cnt == '0) begin
                            res_valid <= 1'b1;
                            res_data  <= red_result & sew_mask(sew_q);
                            res_err   <= !last_q;
                            state     <= S_DONE;
                        end else begin
                            state <= S_FOLD_ISSUE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_ACC_ISSUE;
                    end
                end
                S_FOLD_ISSUE: begin
                    state <= S_FOLD_WAIT;
                end
                S_FOLD_WAIT: begin
                    acc <= red_result;
                    if (fidx == fold_cnt - SEW_WIDTH'(1)) begin
                        res_valid <= 1'b1;
                        res_data  <= red_result & sew_mask(sew_q);
                        res_err   <= err_q;
                        state     <= S_DONE;
                    end else begin
                        fidx  <= fidx + SEW_WIDTH'(1);
                        state <= S_FOLD_ISSUE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_data  <= '0;
                        res_err   <= 1'b0;
                        err_q     <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vred_seq_ctrl.sv
// Bench for vred_seq_ctrl: a stand-in reduction block plus a flat element-list
// reference model of each reduction's scalar result, error flag and latency.
module tb_vred_seq_ctrl;

    localparam int DW = 64;
    localparam int OW = 9;
    localparam int SW = 2;
    localparam int MB = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_last = 1'b0;
    logic [SW-1:0]   sew = '0;
    logic [OW-1:0]   opSel = '0;
    logic            red_en;
    logic [SW-1:0]   red_sew;
    logic [OW-1:0]   red_opSel;
    logic [2*DW-1:0] red_vec0;
    logic [DW-1:0]   red_result = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW-1:0]   res_data;
    logic            res_err;
    logic            busy;

    int total = 0;
    int bad   = 0;

    vred_seq_ctrl #(
        .DATA_WIDTH(DW), .OPSEL_WIDTH(OW), .SEW_WIDTH(SW), .MAX_BEATS(MB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .sew(sew), .opSel(opSel),
        .red_en(red_en), .red_sew(red_sew), .red_opSel(red_opSel), .red_vec0(red_vec0),
        .red_result(red_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mask_of(input logic [1:0] s);
        int w;
        w = 8 << s;
        if (w == 64) return '1;
        return (64'h1 << w) - 64'h1;
    endfunction

    function automatic logic [63:0] lane(input logic [63:0] x, input int i, input logic [1:0] s);
        return (x >> (i * (8 << s))) & mask_of(s);
    endfunction

    function automatic logic signed [63:0] sext(input logic [63:0] a, input logic [1:0] s);
        int sh;
        logic signed [63:0] t;
        sh = 64 - (8 << s);
        t = a << sh;
        return t >>> sh;
    endfunction

    // Element operation: opSel[3] sum, else min/max; opSel[1] signed, opSel[0] max.
    function automatic logic [63:0] combine(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] s, input logic [8:0] op);
        bit a_lt_b;
        if (op[3]) return (a + b) & mask_of(s);
        a_lt_b = op[1] ? (sext(a, s) < sext(b, s)) : (a < b);
        if (op[0]) return a_lt_b ? b : a;
        return a_lt_b ? a : b;
    endfunction

    function automatic logic [63:0] blk_op(input logic en, input logic [1:0] s,
                                           input logic [8:0] op, input logic [127:0] v);
        logic [63:0] r;
        int w;
        if (!en) return v[63:0];
        w = 8 << s;
        r = '0;
        for (int i = 0; i < 64 / w; i++)
            r |= combine(lane(v[63:0], i, s), lane(v[127:64], i, s), s, op) << (i * w);
        return r;
    endfunction

    // Stand-in reduction block: registered, one cycle of latency.
    always @(posedge clk) red_result <= blk_op(red_en, red_sew, red_opSel, red_vec0);

    // Stream description and expected results.
    logic [63:0] s_data [32];
    bit          s_last [32];
    logic [1:0]  t_sew;
    logic [8:0]  t_op;

    logic [63:0] exp_data [$];
    bit          exp_err  [$];
    int          exp_n    [$];

    logic [63:0]  log_data [8];
    bit           log_err  [8];
    int           log_lat  [8];
    int           log_n    [8];
    logic [127:0] fold_vec;
    bit           fold_seen;

    function automatic logic [63:0] ref_reduce(input int first, input int n);
        logic [63:0] r;
        bit started;
        r = '0;
        started = 0;
        for (int b = first; b < first + n; b++)
            for (int i = 0; i < 64 / (8 << t_sew); i++) begin
                r = started ? combine(r, lane(s_data[b], i, t_sew), t_sew, t_op)
                            : lane(s_data[b], i, t_sew);
                started = 1;
            end
        return r;
    endfunction

    task automatic build_expected(input int nb);
        int i, first, n;
        bit last;
        exp_data.delete(); exp_err.delete(); exp_n.delete();
        i = 0;
        while (i < nb) begin
            first = i; n = 0; last = 0;
            while (i < nb && !last && n < MB) begin
                last = s_last[i];
                n++; i++;
            end
            exp_data.push_back(ref_reduce(first, n));
            exp_err.push_back(!last && n == MB);
            exp_n.push_back(n);
        end
    endtask

    task automatic run_stream(input int nb, input int rdelay);
        int idx, k, cyc, first_cyc, racc, hold, lat, f;
        bit pend, in_red, seen, hs_pend;
        logic [63:0] snap_d;
        logic snap_e;
        build_expected(nb);
        idx = 0; k = 0; cyc = 0; first_cyc = 0; racc = 0; hold = 0;
        pend = 0; in_red = 0; seen = 0; hs_pend = 0; fold_seen = 0;
        snap_d = '0; snap_e = 0;
        f = 3 - int'(t_sew);
        while (k < exp_data.size()) begin
            @(negedge clk);
            cyc++;
            if (cyc > 600) begin
                total++; bad++;
                $display("FAIL stream_timeout: results=%0d required=%0d", k, exp_data.size());
                break;
            end
            if (pend) begin idx++; pend = 0; end
            if (hs_pend) begin
                hs_pend = 0; res_ready = 1'b0; k++;
                total++;
                if (!(in_ready === 1'b1 && res_valid === 1'b0 && busy === 1'b0)) begin
                    bad++;
                    $display("FAIL post_handshake_idle: in_ready=%b res_valid=%b busy=%b required 1 0 0",
                             in_ready, res_valid, busy);
                end
            end
            if (red_en === 1'b1 && in_ready === 1'b0 && !fold_seen) begin
                fold_vec = red_vec0; fold_seen = 1;
            end
            if (res_valid === 1'b1 && k < exp_data.size()) begin
                if (!seen) begin
                    seen = 1; hold = 0;
                    lat = cyc - first_cyc;
                    snap_d = res_data; snap_e = res_err;
                    if (k < 8) begin
                        log_data[k] = res_data; log_err[k] = res_err;
                        log_lat[k] = lat; log_n[k] = racc;
                    end
                    total++;
                    if (res_data !== exp_data[k]) begin
                        bad++;
                        $display("FAIL res_data[%0d]: got %h required %h", k, res_data, exp_data[k]);
                    end
                    total++;
                    if (res_err !== exp_err[k]) begin
                        bad++;
                        $display("FAIL res_err[%0d]: got %b required %b", k, res_err, exp_err[k]);
                    end
                    total++;
                    if (racc != exp_n[k]) begin
                        bad++;
                        $display("FAIL beats_accepted[%0d]: got %0d required %0d", k, racc, exp_n[k]);
                    end
                    total++;
                    if (lat != 2 * exp_n[k] + 2 * f) begin
                        bad++;
                        $display("FAIL latency[%0d]: got %0d required %0d", k, lat, 2 * exp_n[k] + 2 * f);
                    end
                end else begin
                    total++;
                    if (res_data !== snap_d || res_err !== snap_e) begin
                        bad++;
                        $display("FAIL result_stable[%0d]: got %h/%b required %h/%b",
                                 k, res_data, res_err, snap_d, snap_e);
                    end
                end
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL in_ready_in_done[%0d]: got %b required 0", k, in_ready);
                end
                if (hold >= rdelay) begin
                    res_ready = 1'b1; hs_pend = 1; seen = 0; in_red = 0;
                end
                hold++;
            end
            in_valid = (idx < nb);
            in_data  = (idx < nb) ? s_data[idx] : '0;
            in_last  = (idx < nb) ? s_last[idx] : 1'b0;
            sew      = in_red ? 2'($urandom) : t_sew;
            opSel    = in_red ? 9'($urandom) : t_op;
            #1;
            if (in_valid && in_ready === 1'b1) begin
                pend = 1;
                total++;
                if (!in_red) begin
                    in_red = 1; first_cyc = cyc; racc = 0; fold_seen = 0;
                    if (red_en !== 1'b0 || red_vec0 !== {64'h0, in_data}) begin
                        bad++;
                        $display("FAIL first_beat_copy: en=%b vec=%h required en=0 vec=%h",
                                 red_en, red_vec0, {64'h0, in_data});
                    end
                end else if (red_en !== 1'b1 || red_vec0[127:64] !== in_data) begin
                    bad++;
                    $display("FAIL acc_beat_issue: en=%b hi=%h required en=1 hi=%h",
                             red_en, red_vec0[127:64], in_data);
                end
                racc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    endtask

    task automatic load_test1();
        t_sew = 2'd2; t_op = 9'h008;
        s_data[0] = 64'h00000002_00000001; s_last[0] = 0;
        s_data[1] = 64'h00000004_00000003; s_last[1] = 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++;
        if ({in_ready, res_valid, res_err, busy, red_en, red_sew, red_opSel, res_data, red_vec0} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: in_ready=%b res_valid=%b busy=%b res_data=%h required all 0",
                     in_ready, res_valid, busy, res_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_sum32();
        load_test1();
        run_stream(2, 0);
        total++;
        if (fold_vec !== {64'h00000000_00000006, 64'h00000006_00000004}) begin
            bad++;
            $display("FAIL sum32_acc: got %h required %h", fold_vec,
                     {64'h00000000_00000006, 64'h00000006_00000004});
        end
        total++;
        if (log_data[0] !== 64'h0A || log_lat[0] != 6 || log_err[0] !== 1'b0) begin
            bad++;
            $display("FAIL sum32_result: got %h lat=%0d err=%b required 0a lat=6 err=0",
                     log_data[0], log_lat[0], log_err[0]);
        end
    endtask

    task automatic test_sum8();
        t_sew = 2'd0; t_op = 9'h008;
        s_data[0] = 64'h08070605_04030201; s_last[0] = 1;
        run_stream(1, 0);
        total++;
        if (log_data[0] !== 64'h24 || log_lat[0] != 8) begin
            bad++;
            $display("FAIL sum8_result: got %h lat=%0d required 24 lat=8", log_data[0], log_lat[0]);
        end
    endtask

    task automatic test_sew64_copy();
        t_sew = 2'd3; t_op = 9'h003;
        s_data[0] = 64'hDEADBEEF_01234567; s_last[0] = 1;
        run_stream(1, 0);
        total++;
        if (log_data[0] !== 64'hDEADBEEF_01234567 || log_lat[0] != 2 || fold_seen) begin
            bad++;
            $display("FAIL sew64_result: got %h lat=%0d folded=%b required deadbeef01234567 lat=2 folded=0",
                     log_data[0], log_lat[0], fold_seen);
        end
    endtask

    task automatic test_max_beats();
        t_sew = 2'd2; t_op = 9'h008;
        for (int i = 0; i < 6; i++) begin
            s_data[i] = {32'(i + 1), 32'(i + 1)};
            s_last[i] = (i == 5);
        end
        run_stream(6, 2);
        total++;
        if (log_data[0] !== 64'h14 || log_err[0] !== 1'b1 || log_n[0] != 4 || log_lat[0] != 10) begin
            bad++;
            $display("FAIL max_beats_first: got %h err=%b n=%0d lat=%0d required 14 err=1 n=4 lat=10",
                     log_data[0], log_err[0], log_n[0], log_lat[0]);
        end
        total++;
        if (log_data[1] !== 64'h16 || log_err[1] !== 1'b0 || log_n[1] != 2) begin
            bad++;
            $display("FAIL max_beats_second: got %h err=%b n=%0d required 16 err=0 n=2",
                     log_data[1], log_err[1], log_n[1]);
        end
    endtask

    task automatic test_backpressure();
        load_test1();
        run_stream(2, 5);
        total++;
        if (log_data[0] !== 64'h0A) begin
            bad++;
            $display("FAIL backpressure_result: got %h required 0a", log_data[0]);
        end
    endtask

    task automatic test_reset_midfold();
        load_test1();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            in_valid = (c <= 2);
            in_data  = (c == 0) ? s_data[0] : s_data[1];
            in_last  = (c != 0);
            sew = t_sew; opSel = t_op;
            #1;
            if (c == 4) begin
                total++;
                if (red_en !== 1'b1) begin
                    bad++;
                    $display("FAIL midfold_issue: red_en=%b required 1", red_en);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || red_en !== 1'b0) begin
            bad++;
            $display("FAIL midfold_wait: busy=%b red_en=%b required 1 0", busy, red_en);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({in_ready, res_valid, res_err, busy, red_en, red_sew, red_opSel, res_data, red_vec0} !== '0) begin
            bad++;
            $display("FAIL async_reset: busy=%b in_ready=%b red_en=%b required all 0", busy, in_ready, red_en);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_stream(2, 1);
        total++;
        if (log_data[0] !== 64'h0A) begin
            bad++;
            $display("FAIL after_reset_result: got %h required 0a", log_data[0]);
        end
    endtask

    task automatic test_random();
        int nb;
        for (int r = 0; r < 8; r++) begin
            t_sew = 2'($urandom);
            t_op  = 9'($urandom);
            nb    = $urandom_range(1, 12);
            for (int i = 0; i < nb; i++) begin
                s_data[i] = {$urandom, $urandom};
                s_last[i] = (i == nb - 1) || ($urandom_range(0, 2) == 0);
            end
            run_stream(nb, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_sum32();
        test_sum8();
        test_sew64_copy();
        test_max_beats();
        test_backpressure();
        test_reset_midfold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vred_seq_ctrl.md
Name: vred_seq_ctrl

Overview:
- Initiator/sequencer that drives the vector reduction sum/min/max unit block.
- Accepts a stream of 64-bit source beats for one reduction and folds each beat lane-wise into an accumulator using the block.
- Then folds the accumulator horizontally down to one SEW-wide element and returns it as a zero-extended scalar over a valid/ready result port.
- Sits between the vALU issue logic and the reduction block instance.

Parameters:
- DATA_WIDTH, 64, beat and accumulator width; the reduction block is instantiated with REQ_DATA_WIDTH = DATA_WIDTH.
- OPSEL_WIDTH, 9, opSel width forwarded to the block.
- SEW_WIDTH, 2, element-width code: 0=8b, 1=16b, 2=32b, 3=64b.
- MAX_BEATS, 16, maximum beats per reduction before forced termination.
- CNT_W, 5, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  source beat valid
- in_ready  out  1  sequencer can accept a beat
- in_data  in  DATA_WIDTH  source beat
- in_last  in  1  final beat of this reduction
- sew  in  SEW_WIDTH  element width; sampled with the first beat
- opSel  in  OPSEL_WIDTH  operation select; sampled with the first beat; opSel[3]=1 selects sum, opSel[3]=0 selects min/max
- red_en  out  1  block enable; 0 selects copy of the low operand
- red_sew  out  SEW_WIDTH  latched sew
- red_opSel  out  OPSEL_WIDTH  latched opSel
- red_vec0  out  2*DATA_WIDTH  {operand_hi, operand_lo} to the block
- red_result  in  DATA_WIDTH  block output (registered, 1-cycle latency)
- res_valid  out  1  scalar result valid
- res_ready  in  1  result consumer ready
- res_data  out  DATA_WIDTH  result element, zero-extended from SEW
- res_err  out  1  reduction terminated by the MAX_BEATS limit
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, cnt=0, fold index=0; all outputs 0 except in_ready=1 after release.
- The block's own sync reset is tied inactive by the parent.
- States: IDLE, ACC_WAIT, ACC_ISSUE, FOLD_ISSUE, FOLD_WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch sew/opSel, cnt=1, drive red_en=0 and red_vec0={0,in_data} (copy), go to ACC_WAIT.
- ACC_ISSUE:
  - in_ready=1.
  - On in_valid: red_en=1, red_vec0={in_data, acc}, cnt++, go to ACC_WAIT.
  - Otherwise stay; red_en=0 and red_vec0=0.
- ACC_WAIT:
  - in_ready=0; acc <= red_result.
  - Next state is FOLD_ISSUE if the last accepted beat had in_last=1 or cnt==MAX_BEATS (the latter sets err).
  - Otherwise next state is ACC_ISSUE.
- Folding:
  - Fold count F = 3 - sew, giving shifts 32, 16, 8 in that order, truncated to the first F.
  - If F=0, go straight to DONE.
- FOLD_ISSUE: red_en=1, red_vec0={acc >> shift, acc}, go to FOLD_WAIT.
- FOLD_WAIT: acc <= red_result; go to FOLD_ISSUE for the next shift, or to DONE after the last.
- DONE:
  - res_valid=1, res_data=acc masked to SEW bits, res_err=err.
  - All three are held stable until res_ready; in_ready=0.
  - On res_valid && res_ready: go to IDLE, clear err.
- red_* outputs are combinational from state/acc/in_data. They are 0 in WAIT and DONE states and during IDLE/ACC_ISSUE without in_valid.
- Arithmetic is entirely inside the block: lane-wise, sums wrap modulo 2^SEW, min/max signedness per opSel. Upper lanes after a fold are don't-care.
- Timing with continuous in_valid, first beat accepted at cycle 0:
  - N beats and F folds give res_valid first high at cycle 2N + 2F.
- Termination corner cases:
  - in_last on the first beat: copy only, then fold.
  - in_last coinciding with cnt==MAX_BEATS: err=0.
  - Beats after forced termination wait (in_ready=0) and begin the next reduction.
- sew/opSel changes mid-reduction are ignored (latched copies are used).

Test Plan:
1. sew=2, sum: beats 0x00000002_00000001, then 0x00000004_00000003 with last.
   - Expect acc=0x00000006_00000004, then res_data=0x0000000A, res_valid at cycle 6, res_err=0.
2. sew=0, sum: single beat 0x0807060504030201 with last.
   - Expect 3 folds, res_data=0x24, res_valid at cycle 8.
3. sew=3: single beat 0xDEADBEEF_01234567 with last.
   - Expect red_en=0 copy, no folds, res_data=0xDEADBEEF01234567 at cycle 2.
4. MAX_BEATS=4: five sum beats, none with last, sew=2.
   - Expect only 4 beats accepted, res_err=1.
   - The 5th beat stays pending with in_ready=0 until the result handshake, then starts a new reduction.
5. res_ready held low 5 cycles in DONE.
   - Expect res_valid, res_data, res_err stable and in_ready=0; one handshake cycle later, IDLE with in_ready=1.
6. rst pulsed low during FOLD_WAIT.
   - Expect all outputs 0 immediately, without waiting for a clock edge.
   - After release, a test-1 stream produces 0x0A again.
